// File: rtl/mic_pkg.sv
// Shared types and the sample scaling helper for the microphone frame capture block.
package mic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PUBLISH = 2'd2
    } mic_cap_state_t;

    localparam int MIC_MAX_W = 64;

    // Offset-binary to OUT_W conversion; callers truncate the wide result to OUT_W.
    function automatic logic [MIC_MAX_W-1:0] mic_scale(
        input logic [MIC_MAX_W-1:0] sample,
        input int                   sample_w,
        input int                   shift,
        input bit                   signed_out
    );
        logic [MIC_MAX_W-1:0] v;
        logic [5:0]           msb;
        msb = 6'(sample_w - 1);
        v   = sample;
        if (signed_out) begin
            v[msb] = ~v[msb];
        end
        for (int i = 0; i < MIC_MAX_W; i++) begin
            if (i >= sample_w) begin
                v[i] = signed_out ? v[msb] : 1'b0;
            end
        end
        return v << shift;
    endfunction

endpackage

// File: rtl/mic_decimator.sv
// Strobe decimator: accepts every DECIM-th strobe, restarting the phase on clr.
module mic_decimator #(
    parameter int DECIM = 1
) (
    input  logic i_clk_25,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_strobe,
    output logic o_accept
);
    import mic_pkg::*;

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_accept = i_strobe && (r_cnt == '0);

    always_ff @(posedge i_clk_25) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_strobe) begin
            r_cnt <= (r_cnt == CNT_W'(DECIM - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mic_frame_capture.sv
// Collects N_SAMPLES decimated ADC samples, scales them and publishes the frame with a done pulse.
module mic_frame_capture
    import mic_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int OUT_W      = 18,
    parameter int N_SAMPLES  = 16,
    parameter int DECIM      = 1,
    parameter int SHIFT      = 6,
    parameter int SIGNED_OUT = 0
) (
    input  logic                       i_clk_25,
    input  logic                       i_reset,
    input  logic [SAMPLE_W-1:0]        i_sample,
    input  logic                       i_sample_valid,
    input  logic                       i_start,
    input  logic                       i_cont,
    input  logic                       i_stop,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overrun,
    output logic [N_SAMPLES*OUT_W-1:0] o_frame_out
);
    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    if (SAMPLE_W + SHIFT > OUT_W) begin : g_bad_width
        $error("mic_frame_capture: SAMPLE_W + SHIFT exceeds OUT_W");
    end
    if (OUT_W > MIC_MAX_W) begin : g_bad_out_w
        $error("mic_frame_capture: OUT_W exceeds MIC_MAX_W");
    end
    if (N_SAMPLES < 2) begin : g_bad_n
        $error("mic_frame_capture: N_SAMPLES must be at least 2");
    end
    if (DECIM < 1) begin : g_bad_decim
        $error("mic_frame_capture: DECIM must be at least 1");
    end

    mic_cap_state_t             r_state;
    mic_cap_state_t             w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [OUT_W-1:0]           r_buf [N_SAMPLES];
    logic [N_SAMPLES*OUT_W-1:0] r_frame;
    logic                       r_done;
    logic                       r_overrun;
    logic                       w_accept;
    logic                       w_clr;
    logic                       w_begin;
    logic                       w_store;
    logic                       w_publish;
    logic [OUT_W-1:0]           w_scaled;

    mic_decimator #(.DECIM(DECIM)) u_decim (
        .i_clk_25 (i_clk_25),
        .i_reset  (i_reset),
        .i_clr    (w_clr),
        .i_strobe (i_sample_valid),
        .o_accept (w_accept)
    );

    assign w_scaled = OUT_W'(mic_scale(MIC_MAX_W'(i_sample), SAMPLE_W, SHIFT, SIGNED_OUT != 0));

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_begin     = 1'b0;
        w_store     = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nxt = ST_CAPTURE;
                    w_clr       = 1'b1;
                    w_begin     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_store = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                w_publish = 1'b1;
                if (i_cont && !i_stop) begin
                    w_state_nxt = ST_CAPTURE;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_25) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_frame   <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_publish;
            if (w_clr) begin
                r_idx <= '0;
            end else if (w_store) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_publish) begin
                for (int i = 0; i < N_SAMPLES; i++) begin
                    r_frame[i*OUT_W +: OUT_W] <= r_buf[i];
                end
            end
            // A strobe landing in the single publish cycle has nowhere to go.
            if (w_begin) begin
                r_overrun <= 1'b0;
            end else if (r_state == ST_PUBLISH && w_accept) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_25) begin
        if (w_store) begin
            r_buf[r_idx] <= w_scaled;
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_overrun   = r_overrun;
    assign o_frame_out = r_frame;

endmodule
